// File: rtl/uart_fifo_param.sv
// Parametrised synchronous single-clock FIFO for the UART TX/RX paths.
// Depth is 2**AW entries of DW bits each. The block provides:
//   - a registered read port with one cycle of latency,
//   - an exact occupancy count,
//   - programmable almost-full and almost-empty flags,
//   - sticky overflow and underflow flags that clear only on err_clr.
module uart_fifo_param #(
  parameter int DW = 8,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst_,
  input  logic          fifo_rst,
  input  logic          winc,
  input  logic [DW-1:0] data_i,
  input  logic          rinc,
  output logic [DW-1:0] data_o,
  output logic          wfull,
  output logic          rempty,
  output logic          afull,
  output logic          aempty,
  input  logic [AW:0]   afull_lvl,
  input  logic [AW:0]   aempty_lvl,
  output logic [AW:0]   fifo_cnt,
  output logic          ovf,
  output logic          udf,
  input  logic          err_clr
);

  localparam int          DEPTH = 1 << AW;
  localparam logic [AW:0] ONE   = {{AW{1'b0}}, 1'b1};

  // Storage has no reset; entries are only meaningful once written.
  logic [DW-1:0] ram_r [DEPTH];

  // Pointers carry one extra wrap bit so that full and empty can be told apart.
  logic [AW:0]   wptr_r;
  logic [AW:0]   rptr_r;
  logic [AW:0]   cnt_r;
  logic [DW-1:0] data_r;
  logic          ovf_r;
  logic          udf_r;

  logic          full_s;
  logic          empty_s;
  logic          wr_ok_s;
  logic          rd_ok_s;
  logic          ovf_set_s;
  logic          udf_set_s;

  // Status flags and request acceptance, judged on pointers before the edge.
  always_comb begin
    empty_s   = (wptr_r == rptr_r);
    full_s    = (wptr_r[AW] != rptr_r[AW]) && (wptr_r[AW-1:0] == rptr_r[AW-1:0]);
    wr_ok_s   = winc & ~full_s & ~fifo_rst;
    rd_ok_s   = rinc & ~empty_s & ~fifo_rst;
    ovf_set_s = winc & full_s & ~fifo_rst;
    udf_set_s = rinc & empty_s & ~fifo_rst;
  end

  // Write and read pointers; a flush returns both to zero.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      wptr_r <= {(AW+1){1'b0}};
      rptr_r <= {(AW+1){1'b0}};
    end else if (fifo_rst) begin
      wptr_r <= {(AW+1){1'b0}};
      rptr_r <= {(AW+1){1'b0}};
    end else begin
      if (wr_ok_s) begin
        wptr_r <= wptr_r + ONE;
      end
      if (rd_ok_s) begin
        rptr_r <= rptr_r + ONE;
      end
    end
  end

  // Occupancy count tracks wptr - rptr exactly, with no lag.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      cnt_r <= {(AW+1){1'b0}};
    end else if (fifo_rst) begin
      cnt_r <= {(AW+1){1'b0}};
    end else begin
      case ({wr_ok_s, rd_ok_s})
        2'b10:   cnt_r <= cnt_r + ONE;
        2'b01:   cnt_r <= cnt_r - ONE;
        default: cnt_r <= cnt_r;
      endcase
    end
  end

  // Storage write port.
  always_ff @(posedge clk) begin
    if (wr_ok_s) begin
      ram_r[wptr_r[AW-1:0]] <= data_i;
    end
  end

  // Registered read data; holds its value unless a read is accepted.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      data_r <= {DW{1'b0}};
    end else if (rd_ok_s) begin
      data_r <= ram_r[rptr_r[AW-1:0]];
    end
  end

  // Sticky error flags. A set wins over err_clr, and a flush leaves them alone.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      ovf_r <= 1'b0;
      udf_r <= 1'b0;
    end else begin
      if (ovf_set_s) begin
        ovf_r <= 1'b1;
      end else if (err_clr) begin
        ovf_r <= 1'b0;
      end
      if (udf_set_s) begin
        udf_r <= 1'b1;
      end else if (err_clr) begin
        udf_r <= 1'b0;
      end
    end
  end

  assign data_o   = data_r;
  assign fifo_cnt = cnt_r;
  assign wfull    = full_s;
  assign rempty   = empty_s;
  assign ovf      = ovf_r;
  assign udf      = udf_r;
  assign afull    = (cnt_r >= afull_lvl);
  assign aempty   = (cnt_r <= aempty_lvl);

endmodule

// File: tb/tb_uart_fifo_param.sv
// Directed bench for uart_fifo_param with DW=8 and AW=4.
// Expected values come from hand-computed constants plus a small queue model.
module tb_uart_fifo_param;

  logic       clk;
  logic       rst_;
  logic       fifo_rst;
  logic       winc;
  logic [7:0] data_i;
  logic       rinc;
  logic [7:0] data_o;
  logic       wfull;
  logic       rempty;
  logic       afull;
  logic       aempty;
  logic [4:0] afull_lvl;
  logic [4:0] aempty_lvl;
  logic [4:0] fifo_cnt;
  logic       ovf;
  logic       udf;
  logic       err_clr;

  int total = 0;
  int bad   = 0;

  // Reference model state.
  logic [7:0] q[$];
  logic [7:0] m_dout;
  logic       m_ovf;
  logic       m_udf;

  uart_fifo_param #(.DW(8), .AW(4)) dut (
    .clk(clk), .rst_(rst_), .fifo_rst(fifo_rst), .winc(winc), .data_i(data_i),
    .rinc(rinc), .data_o(data_o), .wfull(wfull), .rempty(rempty), .afull(afull),
    .aempty(aempty), .afull_lvl(afull_lvl), .aempty_lvl(aempty_lvl),
    .fifo_cnt(fifo_cnt), .ovf(ovf), .udf(udf), .err_clr(err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    int n;
    n = q.size();
    chk("cnt",    32'(fifo_cnt), 32'(n));
    chk("rempty", 32'(rempty),   32'(n == 0));
    chk("wfull",  32'(wfull),    32'(n == 16));
    chk("afull",  32'(afull),    32'(n >= int'(afull_lvl)));
    chk("aempty", 32'(aempty),   32'(n <= int'(aempty_lvl)));
    chk("data_o", 32'(data_o),   32'(m_dout));
    chk("ovf",    32'(ovf),      32'(m_ovf));
    chk("udf",    32'(udf),      32'(m_udf));
  endtask

  // One clock: drive the requests, update the model, then check after the edge.
  task automatic cyc(input logic w, input logic [7:0] d, input logic r,
                     input logic fr, input logic ec);
    logic full_b;
    logic empty_b;
    winc = w; data_i = d; rinc = r; fifo_rst = fr; err_clr = ec;
    full_b  = (q.size() == 16);
    empty_b = (q.size() == 0);
    if (fr) begin
      q.delete();
    end else begin
      if (r && !empty_b) m_dout = q.pop_front();
      if (w && !full_b) q.push_back(d);
    end
    if (!fr && w && full_b) m_ovf = 1'b1;
    else if (ec) m_ovf = 1'b0;
    if (!fr && r && empty_b) m_udf = 1'b1;
    else if (ec) m_udf = 1'b0;
    @(posedge clk);
    #1;
    winc = 1'b0; rinc = 1'b0; fifo_rst = 1'b0; err_clr = 1'b0;
    check_all();
  endtask

  task automatic model_reset();
    q.delete();
    m_dout = 8'h00;
    m_ovf  = 1'b0;
    m_udf  = 1'b0;
  endtask

  initial begin
    logic up;
    logic [7:0] nxt;
    rst_ = 1'b0; fifo_rst = 1'b0; winc = 1'b0; rinc = 1'b0; err_clr = 1'b0;
    data_i = 8'h00; afull_lvl = 5'd0; aempty_lvl = 5'd2;
    model_reset();
    #12;
    // Reset state with afull_lvl==0 forces afull high.
    chk("rst_afull0", 32'(afull), 32'd1);
    check_all();
    afull_lvl = 5'd16;
    #1;
    chk("rst_afull16", 32'(afull), 32'd0);
    @(posedge clk); #1;
    rst_ = 1'b1;

    // 1: write 0x01..0x10 then read back in order.
    for (int i = 0; i < 16; i++) begin
      cyc(1'b1, 8'(i + 1), 1'b0, 1'b0, 1'b0);
      chk("t1_cnt", 32'(fifo_cnt), 32'(i + 1));
    end
    chk("t1_full", 32'(wfull), 32'd1);
    chk("t1_ovf", 32'(ovf), 32'd0);
    for (int i = 0; i < 16; i++) begin
      cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      chk("t1_rd", 32'(data_o), 32'(i + 1));
    end
    chk("t1_empty", 32'(rempty), 32'd1);

    // 2: overflow on a 17th write, set beats clear, then clear.
    for (int i = 0; i < 16; i++) cyc(1'b1, 8'(i + 1), 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 8'hAA, 1'b0, 1'b0, 1'b0);
    chk("t2_ovf", 32'(ovf), 32'd1);
    chk("t2_cnt", 32'(fifo_cnt), 32'd16);
    cyc(1'b1, 8'hAB, 1'b0, 1'b0, 1'b1);
    chk("t2_setwins", 32'(ovf), 32'd1);
    for (int i = 0; i < 16; i++) cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    chk("t2_last", 32'(data_o), 32'h10);
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    chk("t2_clr", 32'(ovf), 32'd0);

    // 3: underflow with a simultaneous write on an empty FIFO.
    cyc(1'b1, 8'h55, 1'b1, 1'b0, 1'b0);
    chk("t3_udf", 32'(udf), 32'd1);
    chk("t3_hold", 32'(data_o), 32'h10);
    chk("t3_cnt", 32'(fifo_cnt), 32'd1);
    cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    chk("t3_rd", 32'(data_o), 32'h55);
    cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
    chk("t3_udf_set", 32'(udf), 32'd1);
    chk("t3_hold2", 32'(data_o), 32'h55);
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    chk("t3_clr", 32'(udf), 32'd0);

    // 4: wrap-around between 3 and 10 entries, thresholds above depth.
    afull_lvl = 5'd17; aempty_lvl = 5'd17;
    nxt = 8'h80;
    for (int i = 0; i < 3; i++) begin cyc(1'b1, nxt, 1'b0, 1'b0, 1'b0); nxt++; end
    up = 1'b1;
    for (int i = 0; i < 80; i++) begin
      if (i % 2 == 0) begin
        cyc(1'b1, nxt, 1'b1, 1'b0, 1'b0); nxt++;
      end else begin
        if (q.size() >= 10) up = 1'b0;
        if (q.size() <= 3) up = 1'b1;
        if (up) begin cyc(1'b1, nxt, 1'b0, 1'b0, 1'b0); nxt++; end
        else cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      end
    end
    chk("t4_afull_never", 32'(afull), 32'd0);
    chk("t4_aempty_always", 32'(aempty), 32'd1);
    while (q.size() > 0) cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

    // 5: thresholds 12/2 while filling, then simultaneous read/write when full.
    afull_lvl = 5'd12; aempty_lvl = 5'd2;
    for (int i = 0; i < 16; i++) begin
      cyc(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0, 1'b0);
      if (i == 1) chk("t5_aempty_at2", 32'(aempty), 32'd1);
      if (i == 2) chk("t5_aempty_at3", 32'(aempty), 32'd0);
      if (i == 10) chk("t5_afull_at11", 32'(afull), 32'd0);
      if (i == 11) chk("t5_afull_at12", 32'(afull), 32'd1);
    end
    cyc(1'b1, 8'hEE, 1'b1, 1'b0, 1'b0);
    chk("t5_rd", 32'(data_o), 32'hC0);
    chk("t5_ovf", 32'(ovf), 32'd1);
    chk("t5_cnt", 32'(fifo_cnt), 32'd15);
    while (q.size() > 0) cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    chk("t5_lastrd", 32'(data_o), 32'hCF);

    // 6: flush with 7 entries and ovf still set, then async reset mid-burst.
    for (int i = 0; i < 7; i++) cyc(1'b1, 8'(i + 8'h30), 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 8'h99, 1'b1, 1'b1, 1'b0);
    chk("t6_cnt", 32'(fifo_cnt), 32'd0);
    chk("t6_empty", 32'(rempty), 32'd1);
    chk("t6_hold", 32'(data_o), 32'hCF);
    chk("t6_ovf_kept", 32'(ovf), 32'd1);
    cyc(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
    chk("t6_no_udf", 32'(udf), 32'd0);
    for (int i = 0; i < 3; i++) cyc(1'b1, 8'(i + 8'h40), 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 8'h50, 1'b1, 1'b0, 1'b0);
    winc = 1'b1; rinc = 1'b1; data_i = 8'h60;
    #2;
    rst_ = 1'b0;
    #1;
    model_reset();
    chk("t6_arst_cnt", 32'(fifo_cnt), 32'd0);
    chk("t6_arst_dout", 32'(data_o), 32'h00);
    chk("t6_arst_ovf", 32'(ovf), 32'd0);
    check_all();
    @(posedge clk); #1;
    check_all();
    winc = 1'b0; rinc = 1'b0;
    rst_ = 1'b1;
    cyc(1'b1, 8'h77, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    chk("t6_after", 32'(data_o), 32'h77);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
